// File: rtl/dla_particle_walker.sv
// Random-walk particle for diffusion-limited aggregation: walks from a start point, asks an
// external checker about every position, and paints the pixel where the particle sticks.
module dla_particle_walker #(
    parameter int                HSIZE     = 640,
    parameter int                VSIZE     = 480,
    parameter int                AVN_AW    = 19,
    parameter int                AVN_DW    = 16,
    parameter int                MAX_STEPS = 4096,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1,
    parameter logic [AVN_DW-1:0] COLOR     = {AVN_DW{1'b1}}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             walk_start,
    input  logic [$clog2(HSIZE)-1:0]         walk_init_x,
    input  logic [$clog2(VSIZE)-1:0]         walk_init_y,
    output logic                             walk_busy,
    output logic                             walk_done,
    output logic [1:0]                       walk_status,
    output logic [$clog2(MAX_STEPS+1)-1:0]   walk_steps,
    output logic [$clog2(HSIZE)-1:0]         check_x,
    output logic [$clog2(VSIZE)-1:0]         check_y,
    output logic                             check_start,
    input  logic                             check_done,
    input  logic                             hit_boundary,
    input  logic                             hit_neighbor,
    output logic [AVN_AW-1:0]                vram_avn_address,
    output logic                             vram_avn_write,
    output logic [AVN_DW-1:0]                vram_avn_writedata,
    input  logic                             vram_avn_waitrequest
);

    // state | meaning
    // IDLE  | waiting for walk_start
    // CHECK | one-cycle check_start for the current position
    // WAIT  | waiting for check_done, then resolve the outcome
    // MOVE  | take one random step and advance the LFSR
    // WRITE | paint the stuck pixel, held until the slave accepts
    // DONE  | one-cycle walk_done with status/steps

    localparam int XW = $clog2(HSIZE);
    localparam int YW = $clog2(VSIZE);
    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [15:0]   SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [XW-1:0] X_MAX    = XW'(HSIZE - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(VSIZE - 1);
    localparam logic [SW-1:0] STEP_LIM = SW'(MAX_STEPS);

    localparam logic [1:0] ST_STUCK   = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ESCAPED = 2'd2;
    localparam logic [1:0] ST_INVALID = 2'd3;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CHECK = 6'b000010,
        S_WAIT  = 6'b000100,
        S_MOVE  = 6'b001000,
        S_WRITE = 6'b010000,
        S_DONE  = 6'b100000
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, x_mv;
    logic [YW-1:0]   y_q, y_d, y_mv;
    logic [SW-1:0]   steps_q, steps_d;
    logic [SW-1:0]   steps_out_q, steps_out_d;
    logic [1:0]      status_q, status_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            lfsr_fb;
    logic            start_bad;
    logic [2:0]      dir;

    assign start_bad = (int'(walk_init_x) >= HSIZE) || (int'(walk_init_y) >= VSIZE);
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign dir       = lfsr_q[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (walk_start) begin
                    state_d = start_bad ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: state_d = S_WAIT;
            S_WAIT: begin
                if (check_done) begin
                    if (hit_neighbor)                state_d = S_WRITE;
                    else if (hit_boundary)           state_d = S_DONE;
                    else if (steps_q == STEP_LIM)    state_d = S_DONE;
                    else                             state_d = S_MOVE;
                end
            end
            S_MOVE:  state_d = S_CHECK;
            S_WRITE: begin
                if (!vram_avn_waitrequest) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        walk_busy      = 1'b1;
        walk_done      = 1'b0;
        check_start    = 1'b0;
        vram_avn_write = 1'b0;
        case (state_q)
            S_IDLE:  walk_busy      = 1'b0;
            S_CHECK: check_start    = 1'b1;
            S_WRITE: vram_avn_write = 1'b1;
            S_DONE:  walk_done      = 1'b1;
            default: ;
        endcase
    end

    // Saturating step: a move into a frame edge leaves that coordinate where it is.
    always_comb begin
        x_mv = x_q;
        y_mv = y_q;
        case (dir)
            3'd1, 3'd2, 3'd3: if (x_q != X_MAX) x_mv = x_q + XW'(1);
            3'd5, 3'd6, 3'd7: if (x_q != '0)    x_mv = x_q - XW'(1);
            default: ;
        endcase
        case (dir)
            3'd7, 3'd0, 3'd1: if (y_q != '0)    y_mv = y_q - YW'(1);
            3'd3, 3'd4, 3'd5: if (y_q != Y_MAX) y_mv = y_q + YW'(1);
            default: ;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        steps_d     = steps_q;
        lfsr_d      = lfsr_q;
        status_d    = status_q;
        steps_out_d = steps_out_q;
        case (state_q)
            S_IDLE: begin
                if (walk_start) begin
                    steps_d = '0;
                    if (start_bad) begin
                        status_d    = ST_INVALID;
                        steps_out_d = '0;
                    end else begin
                        x_d = walk_init_x;
                        y_d = walk_init_y;
                    end
                end
            end
            S_WAIT: begin
                if (check_done && !hit_neighbor) begin
                    if (hit_boundary) begin
                        status_d    = ST_ESCAPED;
                        steps_out_d = steps_q;
                    end else if (steps_q == STEP_LIM) begin
                        status_d    = ST_TIMEOUT;
                        steps_out_d = steps_q;
                    end
                end
            end
            S_MOVE: begin
                x_d     = x_mv;
                y_d     = y_mv;
                steps_d = steps_q + SW'(1);
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
            end
            S_WRITE: begin
                if (!vram_avn_waitrequest) begin
                    status_d    = ST_STUCK;
                    steps_out_d = steps_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            steps_q     <= '0;
            steps_out_q <= '0;
            status_q    <= '0;
            lfsr_q      <= SEED;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            steps_q     <= steps_d;
            steps_out_q <= steps_out_d;
            status_q    <= status_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign walk_status        = status_q;
    assign walk_steps         = steps_out_q;
    assign check_x            = x_q;
    assign check_y            = y_q;
    assign vram_avn_address   = AVN_AW'(y_q) * AVN_AW'(HSIZE) + AVN_AW'(x_q);
    assign vram_avn_writedata = COLOR;

endmodule

// File: tb/tb_dla_particle_walker.sv
// Scoreboard bench for dla_particle_walker: a reference walk model queues expected positions and
// results; monitors pop them on check_start / walk_done. A second instance runs with MAX_STEPS=8.
`timescale 1ns/1ps
module tb_dla_particle_walker;
    localparam int          HS   = 640;
    localparam int          VS   = 480;
    localparam int          M8   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int status;
        int steps;
        int nwrites;
        int addr;
        int lat;
        int nchecks;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        walk_start, walk_busy, walk_done;
    logic [9:0]  walk_init_x, check_x;
    logic [8:0]  walk_init_y, check_y;
    logic [1:0]  walk_status;
    logic [12:0] walk_steps;
    logic        check_start, check_done, hit_boundary, hit_neighbor;
    logic [18:0] vram_avn_address;
    logic        vram_avn_write, vram_avn_waitrequest;
    logic [15:0] vram_avn_writedata;

    logic        walk_start8, walk_busy8, walk_done8;
    logic [9:0]  walk_init_x8, check_x8;
    logic [8:0]  walk_init_y8, check_y8;
    logic [1:0]  walk_status8;
    logic [3:0]  walk_steps8;
    logic        check_start8, check_done8, hit_boundary8, hit_neighbor8;
    logic [18:0] vram_avn_address8;
    logic        vram_avn_write8, vram_avn_waitrequest8;
    logic [15:0] vram_avn_writedata8;

    dla_particle_walker u_dut (
        .clk(clk), .rst(rst),
        .walk_start(walk_start), .walk_init_x(walk_init_x), .walk_init_y(walk_init_y),
        .walk_busy(walk_busy), .walk_done(walk_done), .walk_status(walk_status), .walk_steps(walk_steps),
        .check_x(check_x), .check_y(check_y), .check_start(check_start), .check_done(check_done),
        .hit_boundary(hit_boundary), .hit_neighbor(hit_neighbor),
        .vram_avn_address(vram_avn_address), .vram_avn_write(vram_avn_write),
        .vram_avn_writedata(vram_avn_writedata), .vram_avn_waitrequest(vram_avn_waitrequest)
    );

    dla_particle_walker #(.MAX_STEPS(M8)) u_dut8 (
        .clk(clk), .rst(rst),
        .walk_start(walk_start8), .walk_init_x(walk_init_x8), .walk_init_y(walk_init_y8),
        .walk_busy(walk_busy8), .walk_done(walk_done8), .walk_status(walk_status8), .walk_steps(walk_steps8),
        .check_x(check_x8), .check_y(check_y8), .check_start(check_start8), .check_done(check_done8),
        .hit_boundary(hit_boundary8), .hit_neighbor(hit_neighbor8),
        .vram_avn_address(vram_avn_address8), .vram_avn_write(vram_avn_write8),
        .vram_avn_writedata(vram_avn_writedata8), .vram_avn_waitrequest(vram_avn_waitrequest8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t        exp_q[$];
    exp_t        exp8_q[$];
    int          pos_q[$];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int dx_of(input int d);
        if (d >= 1 && d <= 3) return 1;
        if (d >= 5) return -1;
        return 0;
    endfunction

    function automatic int dy_of(input int d);
        if (d == 7 || d <= 1) return -1;
        if (d >= 3 && d <= 5) return 1;
        return 0;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_walk(input int x0, input int y0, input int hit, input bit nb, input bit bd,
                              input bit push_exp, input int lat);
        int x, y, steps, d;
        bit fin;
        exp_t e;
        x = x0; y = y0; steps = 0; fin = 0;
        e.lat = lat; e.nwrites = 0; e.addr = 0;
        if (x0 >= HS || y0 >= VS) begin
            e.status = 3; e.steps = 0; e.nchecks = 0;
        end else begin
            while (!fin) begin
                pos_q.push_back(x * 1024 + y);
                if (steps == hit && nb) begin
                    e.status = 0; e.nwrites = 1; e.addr = y * HS + x; fin = 1;
                end else if (steps == hit && bd) begin
                    e.status = 2; fin = 1;
                end else if (steps == 4096) begin
                    e.status = 1; fin = 1;
                end else begin
                    d = int'(m_lfsr % 16'd8);
                    m_lfsr = lfsr_next(m_lfsr);
                    x = clampi(x + dx_of(d), HS - 1);
                    y = clampi(y + dy_of(d), VS - 1);
                    steps++;
                end
            end
            e.steps = steps; e.nchecks = steps + 1;
        end
        if (push_exp) exp_q.push_back(e);
    endtask

    // ---------------- checker responder ----------------
    int resp_k, hit_idx_g, max_dly, resp_dly;
    bit nb_g, bd_g, resp_hold;

    initial begin
        check_done = 0; hit_boundary = 0; hit_neighbor = 0;
        forever begin
            @(negedge clk);
            if (check_start) begin
                @(negedge clk);
                resp_dly = $urandom_range(0, max_dly);
                for (int i = 0; i < resp_dly || resp_hold; i++) begin
                    hit_boundary = 1'($urandom_range(0, 1));
                    hit_neighbor = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                check_done   = 1;
                hit_neighbor = (resp_k == hit_idx_g) && nb_g;
                hit_boundary = (resp_k == hit_idx_g) && bd_g;
                resp_k++;
                @(negedge clk);
                check_done = 0; hit_neighbor = 0; hit_boundary = 0;
            end
        end
    end

    // ---------------- VRAM slave ----------------
    int          stall_g, wcnt, writes_walk, waddr_acc, wdata_acc;
    logic [18:0] waddr0;

    initial begin
        vram_avn_waitrequest = 0; wcnt = 0; writes_walk = 0;
        forever begin
            @(negedge clk);
            if (vram_avn_write) begin
                if (wcnt == 0) waddr0 = vram_avn_address;
                else chk("write_addr_stable", vram_avn_address, waddr0);
                vram_avn_waitrequest = (wcnt < stall_g);
                if (!vram_avn_waitrequest) begin
                    writes_walk++;
                    waddr_acc = int'(vram_avn_address);
                    wdata_acc = int'(vram_avn_writedata);
                end
                wcnt++;
            end else begin
                wcnt = 0;
                vram_avn_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitors ----------------
    int checks_walk = 0;
    int pos;

    initial forever begin
        @(negedge clk);
        if (check_start) begin
            checks_walk++;
            if (pos_q.size() == 0) chk("unexpected_check_start", 1, 0);
            else begin
                pos = pos_q.pop_front();
                chk("check_x", check_x, pos / 1024);
                chk("check_y", check_y, pos % 1024);
            end
        end
    end

    int   cyc = 0;
    int   start_cyc, n_done = 0;
    exp_t mon_e;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (walk_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("status", walk_status, mon_e.status);
                chk("steps", walk_steps, mon_e.steps);
                chk("checks_per_walk", checks_walk, mon_e.nchecks);
                chk("writes_per_walk", writes_walk, mon_e.nwrites);
                if (mon_e.nwrites == 1 && writes_walk == 1) begin
                    chk("write_addr", waddr_acc, mon_e.addr);
                    chk("write_data", wdata_acc, 16'hFFFF);
                end
                if (mon_e.lat >= 0) chk("done_latency", cyc - start_cyc, mon_e.lat);
            end
            writes_walk = 0; checks_walk = 0; n_done++;
            @(negedge clk);
            chk("done_single_pulse", walk_done, 0);
            chk("busy_after_done", walk_busy, 0);
            chk("status_hold", walk_status, mon_e.status);
            chk("steps_hold", walk_steps, mon_e.steps);
        end
    end

    int   c8_pulses = 0, w8 = 0, n_done8 = 0;
    exp_t e8;
    initial forever begin
        @(negedge clk);
        if (check_start8) c8_pulses++;
        if (vram_avn_write8) w8++;
        if (walk_done8) begin
            if (exp8_q.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                e8 = exp8_q.pop_front();
                chk("timeout_status", walk_status8, e8.status);
                chk("timeout_steps", walk_steps8, e8.steps);
                chk("timeout_check_pulses", c8_pulses, e8.nchecks);
                chk("timeout_writes", w8, e8.nwrites);
            end
            n_done8++;
        end
    end

    // ---------------- stimulus ----------------
    bit junk_en = 1;

    task automatic start_walk(input int x, input int y, input int hit, input bit nb, input bit bd,
                              input int stall, input int dly, input int lat, input bit push_exp);
        hit_idx_g = hit; nb_g = nb; bd_g = bd; stall_g = stall; max_dly = dly; resp_k = 0;
        model_walk(x, y, hit, nb, bd, push_exp, lat);
        walk_init_x = 10'(x);
        walk_init_y = 9'(y);
        walk_start  = 1;
        start_cyc   = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        int cnt;
        cnt = 0;
        while (n_done < target && cnt < budget) begin
            @(negedge clk);
            walk_start = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            cnt++;
        end
        walk_start = 0;
        chk("walk_done_seen", n_done >= target, 1);
        if (n_done < target) $fatal(1, "walk did not complete");
        @(negedge clk);
    endtask

    task automatic do_walk(input int x, input int y, input int hit, input bit nb, input bit bd,
                           input int stall, input int dly, input int lat);
        int target;
        target = n_done + 1;
        start_walk(x, y, hit, nb, bd, stall, dly, lat, 1);
        wait_done(target, 5000);
    endtask

    task automatic pulse_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    int   nd, cnt, rx, ry, kind;
    exp_t e8_push;

    initial begin
        rst = 1; walk_start = 0; walk_init_x = 0; walk_init_y = 0;
        walk_start8 = 0; walk_init_x8 = 0; walk_init_y8 = 0;
        check_done8 = 1; hit_boundary8 = 0; hit_neighbor8 = 0; vram_avn_waitrequest8 = 0;
        stall_g = 0; hit_idx_g = -1; nb_g = 0; bd_g = 0; resp_hold = 0; max_dly = 2; resp_k = 0;
        m_lfsr = SEED;
        repeat (3) @(negedge clk);
        chk("rst_busy", walk_busy, 0);
        chk("rst_done", walk_done, 0);
        chk("rst_check_start", check_start, 0);
        chk("rst_write", vram_avn_write, 0);
        chk("rst_status", walk_status, 0);
        chk("rst_steps", walk_steps, 0);
        chk("rst_x", check_x, 0);
        chk("rst_y", check_y, 0);
        rst = 0;
        @(negedge clk);

        // timeout on the MAX_STEPS=8 instance
        e8_push.status = 1; e8_push.steps = M8; e8_push.nchecks = M8 + 1;
        e8_push.nwrites = 0; e8_push.addr = 0; e8_push.lat = -1;
        exp8_q.push_back(e8_push);
        walk_init_x8 = 10'd100; walk_init_y8 = 9'd100; walk_start8 = 1;
        @(negedge clk);
        walk_start8 = 0;
        cnt = 0;
        while (n_done8 < 1 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("timeout_walk_done_seen", n_done8, 1);

        // best-case stuck walk
        do_walk(10, 10, 0, 1, 0, 0, 0, 4);
        // long walk from the corner
        do_walk(0, 0, 64, 1, 0, 0, 2, -1);
        // boundary and neighbor together: neighbor wins
        do_walk(5, 5, 2, 1, 1, 1, 2, -1);
        // stalled write
        do_walk(300, 200, 1, 1, 0, 5, 1, -1);
        // invalid starts
        do_walk(640, 0, -1, 0, 0, 0, 0, 1);
        do_walk(0, 480, -1, 0, 0, 0, 0, 1);
        do_walk(1023, 511, -1, 0, 0, 0, 0, 1);
        // escape at the far corner
        do_walk(HS - 1, VS - 1, 6, 0, 1, 0, 2, -1);

        for (int i = 0; i < 10; i++) begin
            rx   = $urandom_range(0, HS - 1);
            ry   = $urandom_range(0, VS - 1);
            kind = $urandom_range(1, 3);
            do_walk(rx, ry, $urandom_range(0, 20), kind[0], kind[1], $urandom_range(0, 3), 2, -1);
        end

        // reset while waiting for the checker
        junk_en = 0;
        resp_hold = 1; hit_idx_g = -1; resp_k = 0;
        pos_q.push_back(20 * 1024 + 30);
        walk_init_x = 10'd20; walk_init_y = 9'd30; walk_start = 1;
        @(negedge clk);
        walk_start = 0;
        repeat (3) @(negedge clk);
        chk("busy_in_wait", walk_busy, 1);
        nd = n_done;
        pulse_reset();
        chk("abort_wait_busy", walk_busy, 0);
        chk("abort_wait_x", check_x, 0);
        chk("abort_wait_y", check_y, 0);
        chk("abort_wait_status", walk_status, 0);
        resp_hold = 0;
        repeat (6) @(negedge clk);
        chk("abort_wait_no_done", n_done, nd);
        m_lfsr = SEED; checks_walk = 0; writes_walk = 0; pos_q.delete();

        // reset during a stalled write
        start_walk(50, 60, 2, 1, 0, 1000, 1, -1, 0);
        cnt = 0;
        while (!vram_avn_write && cnt < 500) begin @(negedge clk); walk_start = 0; cnt++; end
        walk_start = 0;
        chk("write_reached", vram_avn_write, 1);
        repeat (3) @(negedge clk);
        chk("write_stalled", vram_avn_write, 1);
        nd = n_done;
        pulse_reset();
        chk("abort_write_deasserted", vram_avn_write, 0);
        chk("abort_write_busy", walk_busy, 0);
        stall_g = 0;
        repeat (6) @(negedge clk);
        chk("abort_write_no_done", n_done, nd);
        chk("abort_write_no_accept", writes_walk, 0);
        m_lfsr = SEED; checks_walk = 0; writes_walk = 0; pos_q.delete();

        // walks after reset restart the direction sequence from the seed
        junk_en = 1;
        do_walk(200, 100, 12, 1, 0, 2, 2, -1);
        do_walk(7, 470, 9, 0, 1, 0, 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dla_particle_walker.md
DLA_PARTICLE_WALKER -- requirements
Module: dla_particle_walker

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- HSIZE, 640, frame width in pixels.
- VSIZE, 480, frame height in pixels.
- AVN_AW, 19, VRAM Avalon address width.
- AVN_DW, 16, VRAM Avalon data width.
- MAX_STEPS, 4096, step limit before timeout (>=1).
- LFSR_SEED, 16'hACE1, direction LFSR seed; a value of 0 SHALL be replaced by 1.
- COLOR, all ones, pixel value written on stick.
REQ-002 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk.
REQ-003 Ports SHALL be as follows, one per line (name direction width meaning):
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- walk_start  in  1  start request, sampled in IDLE only.
- walk_init_x  in  $clog2(HSIZE)  start x.
- walk_init_y  in  $clog2(VSIZE)  start y.
- walk_busy  out  1  high in every state except IDLE.
- walk_done  out  1  one-cycle completion pulse.
- walk_status  out  2  0 stuck, 1 timeout, 2 escaped, 3 invalid start; valid with walk_done.
- walk_steps  out  $clog2(MAX_STEPS+1)  moves taken; valid with walk_done.
- check_x  out  $clog2(HSIZE)  current x.
- check_y  out  $clog2(VSIZE)  current y.
- check_start  out  1  one-cycle check request.
- check_done  in  1  check result valid.
- hit_boundary  in  1  particle at a frame edge.
- hit_neighbor  in  1  particle touches the aggregate.
- vram_avn_address  out  AVN_AW  cur_y*HSIZE + cur_x, zero-extended.
- vram_avn_write  out  1  write strobe.
- vram_avn_writedata  out  AVN_DW  COLOR.
- vram_avn_waitrequest  in  1  slave stall.

Function
REQ-004 The walker SHALL implement the one-hot FSM states IDLE, CHECK, WAIT, MOVE, WRITE and DONE.
REQ-005 In IDLE with walk_start=1, the walker SHALL latch init x/y, clear the step counter, and go to CHECK; if init_x>=HSIZE or init_y>=VSIZE it SHALL instead go to DONE with status 3 and issue no check_start.
REQ-006 CHECK SHALL assert check_start for exactly one cycle, then go to WAIT.
REQ-007 WAIT SHALL hold until check_done=1, for an unbounded number of cycles; inputs other than check_done SHALL be ignored while check_done=0.
REQ-008 When check_done=1, the walker SHALL resolve the outcome in this priority order: hit_neighbor -> WRITE; hit_boundary -> DONE status 2; step count == MAX_STEPS -> DONE status 1; otherwise -> MOVE.
REQ-009 MOVE SHALL last one cycle: shift the LFSR once, increment the step counter, update x/y, and go to CHECK.
REQ-010 Direction SHALL be taken from lfsr[2:0] before the shift: 0 N(y-1), 1 NE, 2 E(x+1), 3 SE, 4 S(y+1), 5 SW, 6 W(x-1), 7 NW.
REQ-011 Each coordinate SHALL saturate at 0 and at HSIZE-1/VSIZE-1; there SHALL be no wrap-around.
REQ-012 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting only in MOVE.
REQ-013 WRITE SHALL hold vram_avn_write=1 with a stable address and data until a cycle with waitrequest=0; in that cycle it SHALL go to DONE with status 0.
REQ-014 WRITE SHALL issue exactly one accepted write per stuck walk.
REQ-015 DONE SHALL pulse walk_done for one cycle, drive status and steps, then go to IDLE.
REQ-016 status and steps SHALL hold their values until the next walk_done.
REQ-017 walk_start SHALL be ignored outside IDLE.
REQ-018 Best-case stuck latency SHALL be: start -> CHECK -> WAIT (check_done same cycle) -> WRITE (no stall) -> DONE, i.e. walk_done 4 cycles after start is sampled.
REQ-019 check_x and check_y SHALL always equal the current coordinates.

Reset
REQ-020 On rst the FSM SHALL enter IDLE and the LFSR SHALL load the seed.
REQ-021 On rst, walk_done, walk_busy, check_start and vram_avn_write SHALL be 0.
REQ-022 On rst, walk_status, walk_steps and the coordinates SHALL be 0.
REQ-023 rst asserted mid-walk, including in WRITE during a stall, SHALL abort the walk with no walk_done pulse; write SHALL deassert the next cycle.

Verification
REQ-024 Start (10,10), first check returns neighbor, waitrequest=0 -> one write at address 6410, data 16'hFFFF, status 0, steps 0, done 4 cycles after start.
REQ-025 Start (0,0), 64 non-hit checks -> coordinates never below 0, steps and the LFSR sequence match the reference model.
REQ-026 MAX_STEPS=8, checks never hit -> status 1, steps 8, exactly 9 check_start pulses, no write.
REQ-027 Start (5,5), third check returns hit_boundary and hit_neighbor together -> WRITE taken, status 0.
REQ-028 Neighbor hit, waitrequest held 5 cycles -> write stays high for 6 cycles with stable address; single done pulse.
REQ-029 Start (640,0) -> done next cycle with status 3 and no check_start; rst during WAIT -> IDLE, no done.
